alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl_pkg.sv | 67 ++++++
 rtl/alu_seq_ctrl_if.sv | 24 ++
 rtl/alu_seq_ctrl.sv | 100 ++++++++++
 tb/tb_alu_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the R-type sequencer: ALU function codes, FSM states
// and instruction field positions, also used by the ALU and regbank benches.
package alu_seq_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [5:0] {
    FN_ADD = 6'd0,
    FN_SUB = 6'd1,
    FN_AND = 6'd2,
    FN_OR  = 6'd3,
    FN_XOR = 6'd4,
    FN_NOT = 6'd5,
    FN_SLA = 6'd6,
    FN_SRA = 6'd7,
    FN_SRL = 6'd8
  } funct_e;

  localparam logic [5:0] MAX_FUNCT = 6'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] w);
    return w[OPC_LSB +: 6];
  endfunction

  function automatic logic [REG_AW-1:0] f_rs(input logic [31:0] w);
    return w[RS_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] f_rt(input logic [31:0] w);
    return w[RT_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] f_rd(input logic [31:0] w);
    return w[RD_LSB +: REG_AW];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] w);
    return w[SHAMT_LSB +: 5];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] w);
    return w[FUNCT_LSB +: 6];
  endfunction

  // Only opcode 0 with a known function code is executable.
  function automatic logic f_illegal(input logic [31:0] w);
    return (f_opcode(w) != 6'd0) || (f_funct(w) > MAX_FUNCT);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake between an instruction source and the sequencer,
// including the retire status and counter it reports back.
interface alu_seq_ctrl_if;
  import alu_seq_ctrl_pkg::*;

  logic              start;
  logic [31:0]       instr;
  logic              busy;
  logic              done;
  logic              illegal;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  retired;

  modport master (
    output start, instr,
    input  busy, done, illegal, result, retired
  );

  modport slave (
    input  start, instr,
    output busy, done, illegal, result, retired
  );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Five-state sequencer that reads rs/rt from the regbank, runs them through the
// clocked ALU and writes the result to rd, one instruction every five cycles.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_seq_ctrl_if.slave     bus,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_res
);

  state_e            state, state_nxt;
  logic [31:0]       ir;
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] res_q;
  logic [CNT_W-1:0]  retired_q;
  logic              ir_illegal;
  logic              busy_c, done_c, we_c;

  assign ir_illegal = f_illegal(ir);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    we_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB: begin
        // r0 is architecturally zero, so writes to it are silently dropped
        we_c      = !ir_illegal && (f_rd(ir) != '0);
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= '0;
      opa       <= '0;
      opb       <= '0;
      res_q     <= '0;
      retired_q <= '0;
    end else begin
      if (state == ST_IDLE && bus.start) ir <= bus.instr;
      if (state == ST_READ) begin
        opa <= rf_rd1;
        opb <= rf_rd2;
      end
      if (state == ST_WB && !ir_illegal) res_q <= alu_res;
      if (state == ST_DONE) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.illegal = done_c & ir_illegal;
  assign bus.result  = res_q;
  assign bus.retired = retired_q;

  assign rf_ra1 = f_rs(ir);
  assign rf_ra2 = f_rt(ir);
  assign rf_we  = we_c;
  assign rf_wa  = we_c ? f_rd(ir) : '0;
  assign rf_wd  = we_c ? alu_res : '0;

  // Operands and function come straight from held registers so the ALU input
  // never glitches outside EXEC.
  assign alu_a     = opa;
  assign alu_b     = opb;
  assign alu_shamt = f_shamt(ir);
  assign alu_funct = f_funct(ir);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with behavioural regbank/ALU and an
// architectural reference model of the register file.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_ctrl_if bus();

  logic [REG_AW-1:0] rf_ra1, rf_ra2, rf_wa;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_wd;
  logic              rf_we;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [DATA_W-1:0] alu_res = '0;
  logic [4:0]        alu_shamt;
  logic [5:0]        alu_funct;

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_shamt (alu_shamt),
    .alu_funct (alu_funct),
    .alu_res   (alu_res)
  );

  function automatic logic [31:0] alu_fn(input logic [5:0] fn, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (fn)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd3:    return a | b;
      6'd4:    return a ^ b;
      6'd5:    return ~a;
      6'd6:    return a << sh;
      6'd7:    return $unsigned($signed(a) >>> sh);
      6'd8:    return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  // Environment: regbank with a preload port, and a one-cycle registered ALU
  logic [31:0] rf_mem [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;

  always @(posedge clk) begin
    if (pl_en)                       rf_mem[pl_a]  <= pl_d;
    else if (rf_we && rf_wa != 5'd0) rf_mem[rf_wa] <= rf_wd;
  end
  assign rf_rd1 = rf_mem[rf_ra1];
  assign rf_rd2 = rf_mem[rf_ra2];

  always @(posedge clk) alu_res <= alu_fn(alu_funct, alu_a, alu_b, alu_shamt);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        ill;
    logic [31:0] res;
    logic [15:0] ret;
  } done_t;

  typedef struct {
    int          cyc;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  done_t done_q[$];
  wr_t   wr_q[$];

  logic [31:0] m_rf [32];
  logic [31:0] m_last    = '0;
  logic [15:0] m_retired = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every write and every retirement must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we) begin
        if (wr_q.size() == 0) begin
          check_output("unexpected_write", {27'd0, rf_wa}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check_output("wr_cycle", cyc, w.cyc);
          check_output("wr_addr", {27'd0, rf_wa}, {27'd0, w.wa});
          check_output("wr_data", rf_wd, w.wd);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          check_output("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check_output("done_cycle", cyc, d.cyc);
          check_output("illegal", 32'(bus.illegal), 32'(d.ill));
          check_output("result", bus.result, d.res);
          check_output("retired", 32'(bus.retired), 32'(d.ret));
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again
  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    m_rf[a] = (a == 5'd0) ? 32'd0 : d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // mode 0: start dropped while busy; 1: start held high with junk instr; 2: random start pulses
  task automatic apply_stimulus(input logic [31:0] w, input int mode);
    int          c;
    logic        ill;
    logic [31:0] val;
    c = cyc;
    bus.start = 1'b1;
    bus.instr = w;
    ill = (w[31:26] != 6'd0) || (w[5:0] > 6'd8);
    if (!ill) begin
      val    = alu_fn(w[5:0], m_rf[w[25:21]], m_rf[w[20:16]], w[10:6]);
      m_last = val;
      if (w[15:11] != 5'd0) begin
        wr_q.push_back('{cyc: c + 3, wa: w[15:11], wd: val});
        m_rf[w[15:11]] = val;
      end
    end
    done_q.push_back('{cyc: c + 4, ill: ill, res: m_last, ret: m_retired});
    m_retired = m_retired + 16'd1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        check_output("busy_high", 32'(bus.busy), 32'd1);
        case (mode)
          0: bus.start = 1'b0;
          1: begin bus.start = 1'b1; bus.instr = $urandom; end
          default: begin bus.start = 1'($urandom_range(0, 1)); bus.instr = $urandom; end
        endcase
      end else begin
        check_output("busy_idle", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.instr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_done", 32'(bus.done), 32'd0);
    check_output("rst_illegal", 32'(bus.illegal), 32'd0);
    check_output("rst_result", bus.result, 32'd0);
    check_output("rst_retired", 32'(bus.retired), 32'd0);
    check_output("rst_rf_we", 32'(rf_we), 32'd0);
    check_output("rst_rf_wa", 32'(rf_wa), 32'd0);
    check_output("rst_rf_wd", rf_wd, 32'd0);
    check_output("rst_ra", {rf_ra1, rf_ra2}, 32'd0);
    check_output("rst_alu_a", alu_a, 32'd0);
    check_output("rst_alu_b", alu_b, 32'd0);
    check_output("rst_alu_ctl", {alu_shamt, alu_funct}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) set_reg(5'(i), (i == 0) ? 32'd0 : $urandom);

    // ADD r3 = r1 + r2
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd3);
    apply_stimulus(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0), 0);
    check_output("add_r3", rf_mem[3], 32'd8);

    // Shifts of a negative operand
    set_reg(5'd1, 32'h8000_0000);
    apply_stimulus(mk(6'd0, 5'd1, 5'd2, 5'd4, 5'd4, 6'd7), 0);
    apply_stimulus(mk(6'd0, 5'd1, 5'd2, 5'd5, 5'd4, 6'd8), 2);
    check_output("sra_r4", rf_mem[4], 32'hF800_0000);
    check_output("srl_r5", rf_mem[5], 32'h0800_0000);

    // Illegal funct and opcode: no write, result held
    apply_stimulus(mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'd9), 0);
    apply_stimulus(mk(6'h23, 5'd1, 5'd2, 5'd7, 5'd0, 6'd0), 1);

    // SUB 7-2 into r0 is dropped but still produces a result
    set_reg(5'd8, 32'd7);
    set_reg(5'd9, 32'd2);
    apply_stimulus(mk(6'd0, 5'd8, 5'd9, 5'd0, 5'd0, 6'd1), 0);
    check_output("r0_zero", rf_mem[0], 32'd0);

    // Back-to-back with start held high; second reads the updated r1
    set_reg(5'd1, 32'd10);
    set_reg(5'd2, 32'd4);
    apply_stimulus(mk(6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0), 1);
    apply_stimulus(mk(6'd0, 5'd1, 5'd2, 5'd2, 5'd0, 6'd1), 1);
    check_output("b2b_r2", rf_mem[2], 32'd16);

    // Reset during EXEC: nothing written, nothing retired
    bus.start = 1'b1;
    bus.instr = mk(6'd0, 5'd1, 5'd2, 5'd10, 5'd0, 6'd0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_output("mid_rst_done", 32'(bus.done), 32'd0);
    check_output("mid_rst_retired", 32'(bus.retired), 32'd0);
    check_output("mid_rst_result", bus.result, 32'd0);
    rst = 1'b0;
    m_retired = '0;
    m_last    = '0;
    check_output("mid_rst_r10", rf_mem[10], m_rf[10]);
    apply_stimulus(mk(6'd0, 5'd1, 5'd2, 5'd10, 5'd0, 6'd0), 0);

    // Randomized mix, including illegal words and r0 destinations
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      apply_stimulus(mk(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                        6'($urandom_range(0, 10))), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check_output("done_q_drained", done_q.size(), 32'd0);
    check_output("wr_q_drained", wr_q.size(), 32'd0);
    for (int i = 0; i < 32; i++) check_output("final_rf", rf_mem[i], m_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
